// File: rtl/qds_pkg.sv
// Shared types and sizing helpers for the queue drain serializer.
package qds_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEQ   = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        PAR   = 3'd4,
        DONE  = 3'd5,
        GAP   = 3'd6
    } qds_state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int LAT_CNT_W      = 3;
    localparam int GAP_CNT_W      = 4;

    // One extra bit so a full frame count never wraps.
    function automatic int qds_cnt_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/queue_drain_serializer.sv
// Pops one byte per non-empty queue check and shifts it out LSB-first; frame_done 10 cycles after dequeue,
// ready_in low stalls the line indefinitely. Define QDS_PARITY_EN to append an even-parity bit.
module queue_drain_serializer
    import qds_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int LEN_W       = 4,
    parameter int DEQ_LATENCY = 1,
    parameter int GAP_CYCLES  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              dequeue_out,
    input  logic              ready_in,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              busy_out,
    output logic              frame_done
);

    localparam int CW = qds_cnt_w(DATA_W);
    localparam logic [CW-1:0]        LAST_BIT = CW'(DATA_W - 1);
    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(DEQ_LATENCY - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);

    qds_state_t            r_state;
    qds_state_t            w_next;
    logic [DATA_W-1:0]     r_shreg;
    logic [CW-1:0]         r_bit_cnt;
    logic [LAT_CNT_W-1:0]  r_lat_cnt;
    logic [GAP_CNT_W-1:0]  r_gap_cnt;
    logic                  w_last_bit_acc;
`ifdef QDS_PARITY_EN
    logic                  r_par;
`endif

    assign w_last_bit_acc = ready_in && (r_bit_cnt == LAST_BIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (len_in != '0) w_next = DEQ;
            DEQ:   w_next = WAIT;
            WAIT:  if (r_lat_cnt == LAT_LAST) w_next = SHIFT;
            SHIFT: begin
                if (w_last_bit_acc) begin
`ifdef QDS_PARITY_EN
                    w_next = PAR;
`else
                    w_next = DONE;
`endif
                end
            end
`ifdef QDS_PARITY_EN
            PAR:   if (ready_in) w_next = DONE;
`else
            PAR:   w_next = IDLE;
`endif
            DONE:  w_next = GAP;
            GAP:   if (r_gap_cnt == GAP_LAST) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        dequeue_out  = 1'b0;
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        frame_done   = 1'b0;
        busy_out     = (r_state != IDLE);
        unique case (r_state)
            DEQ:   dequeue_out = 1'b1;
            SHIFT: begin
                serial_valid = 1'b1;
                serial_out   = r_shreg[0];
            end
`ifdef QDS_PARITY_EN
            PAR: begin
                serial_valid = 1'b1;
                serial_out   = r_par;
            end
`endif
            DONE:  frame_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: counters and shift register advance only in their owning state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_lat_cnt <= '0;
            r_gap_cnt <= '0;
`ifdef QDS_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                DEQ:   r_lat_cnt <= '0;
                WAIT: begin
                    r_lat_cnt <= r_lat_cnt + LAT_CNT_W'(1);
                    if (r_lat_cnt == LAT_LAST) begin
                        r_shreg   <= data_in;
                        r_bit_cnt <= '0;
`ifdef QDS_PARITY_EN
                        r_par     <= ^data_in;
`endif
                    end
                end
                SHIFT: begin
                    if (ready_in) begin
                        r_shreg   <= {1'b0, r_shreg[DATA_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                    end
                end
                DONE:  r_gap_cnt <= '0;
                GAP:   r_gap_cnt <= r_gap_cnt + GAP_CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_queue_drain_serializer.sv
// Directed bench: models the byte queue, logs pops, accepted bits and frame_done cycles.
module tb_queue_drain_serializer;

`ifdef QDS_PARITY_EN
    localparam int FRAME_BITS = 9;
    localparam int DONE_OFS   = 11;
`else
    localparam int FRAME_BITS = 8;
    localparam int DONE_OFS   = 10;
`endif
    localparam int SPACING = DONE_OFS + 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] len_in = '0;
    logic [7:0] data_in = '0;
    logic       ready_in = 1'b1;
    logic       dequeue_out, serial_out, serial_valid, busy_out, frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_deq;

    logic [7:0] qbytes[$];
    int         deq_cyc[$];
    int         done_cyc[$];
    logic       bits[$];

    always #5 clock = ~clock;

    queue_drain_serializer dut (
        .clock       (clock),
        .reset       (reset),
        .len_in      (len_in),
        .data_in     (data_in),
        .dequeue_out (dequeue_out),
        .ready_in    (ready_in),
        .serial_out  (serial_out),
        .serial_valid(serial_valid),
        .busy_out    (busy_out),
        .frame_done  (frame_done)
    );

    task automatic push(input logic [7:0] b);
        qbytes.push_back(b);
        len_in = 4'(qbytes.size());
    endtask

    task automatic clear_logs();
        deq_cyc.delete();
        done_cyc.delete();
        bits.delete();
    endtask

    // Observe the current cycle, cross the edge, then act as the queue's read port.
    task automatic tick();
        if (dequeue_out) deq_cyc.push_back(cyc);
        if (serial_valid && ready_in) bits.push_back(serial_out);
        if (frame_done) done_cyc.push_back(cyc);
        prev_deq = dequeue_out;
        @(posedge clock);
        #1;
        cyc++;
        if (prev_deq && !reset) begin
            if (qbytes.size() != 0) begin
                data_in = qbytes.pop_front();
            end
            len_in = 4'(qbytes.size());
        end
    endtask

    function automatic logic [7:0] frame_byte(input int f);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[i] = bits[f*FRAME_BITS + i];
        return b;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        qbytes.delete();
        len_in = '0;
        ready_in = 1'b1;
        tick();
        tick();
        checks++;
        if ({dequeue_out, serial_valid, serial_out, busy_out, frame_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {dequeue_out, serial_valid, serial_out, busy_out, frame_done});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy_out);
        end
    endtask

    task automatic test_basic();
        int c0;
        int d;
        clear_logs();
        ready_in = 1'b1;
        push(8'hA5);
        c0 = cyc;
        for (int i = 0; i < 20; i++) tick();
        d = (deq_cyc.size() != 0) ? deq_cyc[0] : -100;
        checks++;
        if (deq_cyc.size() != 1) begin
            errors++;
            $display("FAIL basic_deq_count: got %0d expected 1", deq_cyc.size());
        end
        checks++;
        if (d != c0 + 1) begin
            errors++;
            $display("FAIL basic_deq_cycle: got %0d expected %0d", d, c0 + 1);
        end
        checks++;
        if (bits.size() != FRAME_BITS || frame_byte(0) !== 8'hA5) begin
            errors++;
            $display("FAIL basic_stream: got %0d bits value %h expected %0d bits value a5",
                     bits.size(), (bits.size() >= 8) ? frame_byte(0) : 8'h00, FRAME_BITS);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] - d != DONE_OFS) begin
            errors++;
            $display("FAIL basic_done_offset: got count %0d offset %0d expected 1 / %0d",
                     done_cyc.size(), (done_cyc.size() != 0) ? done_cyc[0] - d : -1, DONE_OFS);
        end
    endtask

    task automatic test_backpressure();
        int d;
        int stall_left;
        clear_logs();
        stall_left = 5;
        push(8'hA5);
        for (int i = 0; i < 30; i++) begin
            if (serial_valid && bits.size() == 3 && stall_left > 0) begin
                ready_in = 1'b0;
                stall_left--;
                checks++;
                if (serial_valid !== 1'b1 || serial_out !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold: got valid %b bit %b expected valid 1 bit 0",
                             serial_valid, serial_out);
                end
            end else begin
                ready_in = 1'b1;
            end
            tick();
        end
        ready_in = 1'b1;
        d = (deq_cyc.size() != 0) ? deq_cyc[0] : -100;
        checks++;
        if (stall_left != 0) begin
            errors++;
            $display("FAIL stall_applied: got %0d stall cycles left expected 0", stall_left);
        end
        checks++;
        if (bits.size() != FRAME_BITS || frame_byte(0) !== 8'hA5) begin
            errors++;
            $display("FAIL stall_stream: got %0d bits expected %0d of a5", bits.size(), FRAME_BITS);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] - d != DONE_OFS + 5) begin
            errors++;
            $display("FAIL stall_done_offset: got offset %0d expected %0d",
                     (done_cyc.size() != 0) ? done_cyc[0] - d : -1, DONE_OFS + 5);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        exp_b[0] = 8'h01;
        exp_b[1] = 8'h80;
        exp_b[2] = 8'hFF;
        clear_logs();
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) push(exp_b[i]);
        for (int i = 0; i < 3 * SPACING + 10; i++) tick();
        checks++;
        if (deq_cyc.size() != 3) begin
            errors++;
            $display("FAIL b2b_deq_count: got %0d expected 3", deq_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (deq_cyc[i] - deq_cyc[i-1] != SPACING) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d expected %0d",
                             i, deq_cyc[i] - deq_cyc[i-1], SPACING);
                end
            end
        end
        checks++;
        if (bits.size() != 3 * FRAME_BITS) begin
            errors++;
            $display("FAIL b2b_bit_count: got %0d expected %0d", bits.size(), 3 * FRAME_BITS);
        end else begin
            for (int f = 0; f < 3; f++) begin
                checks++;
                if (frame_byte(f) !== exp_b[f]) begin
                    errors++;
                    $display("FAIL b2b_byte%0d: got %h expected %h", f, frame_byte(f), exp_b[f]);
                end
            end
        end
        checks++;
        if (len_in !== 4'd0 || done_cyc.size() != 3) begin
            errors++;
            $display("FAIL b2b_drained: got len %0d done %0d expected 0 / 3", len_in, done_cyc.size());
        end
    endtask

    task automatic test_empty();
        logic any_deq, any_vld, any_busy;
        any_deq = 1'b0;
        any_vld = 1'b0;
        any_busy = 1'b0;
        len_in = '0;
        for (int i = 0; i < 50; i++) begin
            any_deq  |= dequeue_out;
            any_vld  |= serial_valid;
            any_busy |= busy_out;
            tick();
        end
        checks++;
        if (any_deq !== 1'b0) begin
            errors++;
            $display("FAIL empty_deq: got %b expected 0", any_deq);
        end
        checks++;
        if (any_vld !== 1'b0) begin
            errors++;
            $display("FAIL empty_valid: got %b expected 0", any_vld);
        end
        checks++;
        if (any_busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_busy: got %b expected 0", any_busy);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        int c0;
        clear_logs();
        ready_in = 1'b1;
        push(8'h3C);
        n = 0;
        while (!(serial_valid && bits.size() == 4) && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 30 || serial_out !== 1'b1) begin
            errors++;
            $display("FAIL midrst_bit4: got bit %b after %0d cycles expected bit 1", serial_out, n);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({dequeue_out, serial_valid, serial_out, busy_out, frame_done} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got %b expected 00000",
                     {dequeue_out, serial_valid, serial_out, busy_out, frame_done});
        end
        reset = 1'b0;
        clear_logs();
        push(8'h3C);
        c0 = cyc;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (deq_cyc.size() != 1 || deq_cyc[0] != c0 + 1) begin
            errors++;
            $display("FAIL midrst_fresh_deq: got count %0d cycle %0d expected 1 / %0d",
                     deq_cyc.size(), (deq_cyc.size() != 0) ? deq_cyc[0] : -1, c0 + 1);
        end
        checks++;
        if (bits.size() != FRAME_BITS || frame_byte(0) !== 8'h3C) begin
            errors++;
            $display("FAIL midrst_stream: got %0d bits expected %0d of 3c", bits.size(), FRAME_BITS);
        end
    endtask

`ifdef QDS_PARITY_EN
    task automatic test_parity();
        int d;
        clear_logs();
        ready_in = 1'b1;
        push(8'h07);
        for (int i = 0; i < 20; i++) tick();
        d = (deq_cyc.size() != 0) ? deq_cyc[0] : -100;
        checks++;
        if (bits.size() != 9 || frame_byte(0) !== 8'h07 || bits[8] !== 1'b1) begin
            errors++;
            $display("FAIL parity_stream: got %0d bits parity %b expected 9 bits parity 1",
                     bits.size(), (bits.size() == 9) ? bits[8] : 1'bx);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] - d != 11) begin
            errors++;
            $display("FAIL parity_done_offset: got %0d expected 11",
                     (done_cyc.size() != 0) ? done_cyc[0] - d : -1);
        end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_empty();
        test_mid_reset();
`ifdef QDS_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/queue_drain_serializer.md
Name: queue_drain_serializer

Overview:
- Downstream consumer of the byte queue; runs in the queue's clock domain.
- While the queue reports a non-zero length, it issues a single-cycle dequeue and captures the popped byte.
- It then shifts the byte out LSB-first on a serial line under a ready/valid handshake.
- It is the transmit counterpart of the deserializer feeding the queue.

Parameters:
- DATA_W, 8, byte width popped from the queue and serialized.
- LEN_W, 4, width of the queue length input.
- DEQ_LATENCY, 1, cycles from dequeue_out high to data_in valid (1..7).
- GAP_CYCLES, 2, idle cycles after each frame so the queue length can settle (1..15).

Ports:
- clock  in  1  block clock; the same clock that drives the queue.
- reset  in  1  synchronous, active-high reset.
- len_in  in  LEN_W  current queue occupancy.
- data_in  in  DATA_W  queue read data.
- dequeue_out  out  1  one-cycle pop request to the queue.
- ready_in  in  1  downstream accepts the current serial bit this cycle.
- serial_out  out  1  current serial bit.
- serial_valid  out  1  serial_out carries a valid bit.
- busy_out  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Clock and reset: single clock, `clock`. Reset is synchronous and active-high on `reset`; it is sampled only on the rising edge of `clock`.
- Reset values: all outputs 0, state IDLE, shift register 0, counters 0.
- Output style: Moore outputs, all registered from the state.
- IDLE: busy_out=0. If len_in != 0, go to DEQ; otherwise stay.
- DEQ: dequeue_out=1 for exactly one cycle; clear the latency counter; go to WAIT.
- WAIT: count DEQ_LATENCY cycles. On the last one, load data_in into the shift register, set bit_cnt=0, go to SHIFT.
- SHIFT:
  - serial_valid=1 and serial_out=shreg[0].
  - When ready_in=1, the bit is accepted: shift right and increment bit_cnt.
  - When ready_in=0, serial_out and serial_valid hold unchanged with no timeout.
  - After bit DATA_W-1 is accepted, go to DONE (or PAR, see Optional Feature).
- DONE: frame_done=1 for one cycle; go to GAP.
- GAP: wait GAP_CYCLES cycles, then go to IDLE. A non-empty queue is re-checked only from IDLE, which prevents a double pop on stale len_in.
- Bit counter width: $clog2(DATA_W)+1; no wrap inside a frame.
- Timing with DEQ_LATENCY=1, GAP_CYCLES=2 and ready_in held high (edge n is the one on which IDLE sees len_in!=0):
  - Cycle n+1: dequeue_out=1.
  - Cycle n+2: data captured.
  - Cycles n+3..n+10: bits 0..7 presented.
  - Cycle n+11: frame_done=1.
  - Cycles n+12..n+13: GAP.
  - Cycle n+14: IDLE; a new DEQ can occur at n+15.
- Ignored inputs: len_in is ignored outside IDLE. ready_in is ignored outside SHIFT/PAR.
- Reset mid-frame: the next edge returns to IDLE with outputs 0. The in-flight byte is lost because it has already been popped; this is accepted behaviour.
- Simultaneous reset and any event: reset wins.

Optional Feature:
- Macro: QDS_PARITY_EN.
- When defined:
  - After bit DATA_W-1 is accepted, enter state PAR.
  - serial_out = XOR of the captured byte (even parity), serial_valid=1.
  - Same ready_in hold rules as SHIFT; then go to DONE.
  - Frame is DATA_W+1 bits, so in the timing above frame_done moves to n+12.
- When not defined: no PAR state, no parity logic, frame is DATA_W bits.

Decomposition:
- Package qds_pkg holds:
  - state enum qds_state_t (IDLE, DEQ, WAIT, SHIFT, PAR, DONE, GAP); PAR is present in the enum unconditionally.
  - localparam DEFAULT_DATA_W = 8.
  - Helper function for the counter width.
- No sub-module is natural: one FSM plus a datapath, single module.

Test Plan:
- Basic frame: reset for 2 cycles, len_in=1, data_in=8'hA5 from the cycle after dequeue, ready_in=1. Expect: exactly one dequeue_out pulse; serial_out sequence 1,0,1,0,0,1,0,1; frame_done at n+11.
- Backpressure: as the basic frame, but ready_in=0 for 5 cycles while bit 3 is shown. Expect: serial_out and serial_valid hold during the stall; frame_done is delayed by 5 cycles; bit order is unchanged.
- Back-to-back pops: len_in=3 with bytes 8'h01, 8'h80, 8'hFF, each len_in decrementing one cycle after its dequeue. Expect: 3 dequeue pulses, each spaced 14 cycles apart with ready_in high; correct LSB-first streams.
- Empty queue: len_in=0 for 50 cycles. Expect: dequeue_out, serial_valid and busy_out stay 0.
- Mid-frame reset: assert reset while bit 4 of 8'h3C is on the line. Expect: all outputs 0 at the next edge; with len_in=1 after release, a fresh dequeue occurs 1 cycle after IDLE.
- Parity (with QDS_PARITY_EN defined): data 8'h07. Expect: 9 bits, with the ninth bit = 1; frame_done at n+12.
